// File: rtl/admo_mem_arb.sv
// admo_mem_arb: round-robin IF/LSU arbiter issuing one single-beat AXI4 transaction at a time
// Ports: clk; rst (async active-low); if_req/if_addr/if_gnt/if_rvalid/if_rdata fetch port;
//  lsu_req/lsu_we/lsu_addr/lsu_wdata/lsu_be/lsu_gnt/lsu_rvalid/lsu_rdata load/store port;
//  m_axi_* full AXI4 master. Define ADMO_MEM_ARB_RESP_ERR_EN to add if_err/lsu_err,
//  flagging SLVERR/DECERR responses alongside the rvalid pulse.
module admo_mem_arb #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 16,
  parameter int AXI_STRB_WIDTH = DATA_WIDTH/8,
  parameter int AXI_ID_WIDTH   = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      if_req,
  input  logic [ADDR_WIDTH-1:0]     if_addr,
  output logic                      if_gnt,
  output logic                      if_rvalid,
  output logic [DATA_WIDTH-1:0]     if_rdata,
  input  logic                      lsu_req,
  input  logic                      lsu_we,
  input  logic [ADDR_WIDTH-1:0]     lsu_addr,
  input  logic [DATA_WIDTH-1:0]     lsu_wdata,
  input  logic [AXI_STRB_WIDTH-1:0] lsu_be,
  output logic                      lsu_gnt,
  output logic                      lsu_rvalid,
  output logic [DATA_WIDTH-1:0]     lsu_rdata,
`ifdef ADMO_MEM_ARB_RESP_ERR_EN
  output logic                      if_err,
  output logic                      lsu_err,
`endif
  output logic [AXI_ID_WIDTH-1:0]   m_axi_awid,
  output logic [ADDR_WIDTH-1:0]     m_axi_awaddr,
  output logic [7:0]                m_axi_awlen,
  output logic [2:0]                m_axi_awsize,
  output logic [1:0]                m_axi_awburst,
  output logic                      m_axi_awlock,
  output logic [3:0]                m_axi_awcache,
  output logic [2:0]                m_axi_awprot,
  output logic                      m_axi_awvalid,
  input  logic                      m_axi_awready,
  output logic [DATA_WIDTH-1:0]     m_axi_wdata,
  output logic [AXI_STRB_WIDTH-1:0] m_axi_wstrb,
  output logic                      m_axi_wlast,
  output logic                      m_axi_wvalid,
  input  logic                      m_axi_wready,
  input  logic [AXI_ID_WIDTH-1:0]   m_axi_bid,
  input  logic [1:0]                m_axi_bresp,
  input  logic                      m_axi_bvalid,
  output logic                      m_axi_bready,
  output logic [AXI_ID_WIDTH-1:0]   m_axi_arid,
  output logic [ADDR_WIDTH-1:0]     m_axi_araddr,
  output logic [7:0]                m_axi_arlen,
  output logic [2:0]                m_axi_arsize,
  output logic [1:0]                m_axi_arburst,
  output logic                      m_axi_arlock,
  output logic [3:0]                m_axi_arcache,
  output logic [2:0]                m_axi_arprot,
  output logic                      m_axi_arvalid,
  input  logic                      m_axi_arready,
  input  logic [AXI_ID_WIDTH-1:0]   m_axi_rid,
  input  logic [DATA_WIDTH-1:0]     m_axi_rdata,
  input  logic [1:0]                m_axi_rresp,
  input  logic                      m_axi_rlast,
  input  logic                      m_axi_rvalid,
  output logic                      m_axi_rready
);
  localparam logic [ADDR_WIDTH-1:0] AMASK = ~ADDR_WIDTH'(AXI_STRB_WIDTH-1);
  typedef enum logic [2:0] {IDLE, AR, R, WR, B} state_t;
  state_t state;
  logic owner, ptr, win, aw_left, w_left, unused;
  logic [ADDR_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0] wdata;
  logic [AXI_STRB_WIDTH-1:0] be;
  // ptr=1 means LSU has priority on a tie (IF was served last)
  assign win     = lsu_req & (~if_req | ptr);
  assign aw_left = m_axi_awvalid & ~m_axi_awready;
  assign w_left  = m_axi_wvalid & ~m_axi_wready;
  assign unused  = ^{m_axi_bid, m_axi_rid, m_axi_rlast, m_axi_rresp, m_axi_bresp};
  assign m_axi_awid    = AXI_ID_WIDTH'(1);
  assign m_axi_arid    = AXI_ID_WIDTH'(owner);
  assign m_axi_awaddr  = addr;
  assign m_axi_araddr  = addr;
  assign m_axi_awlen   = '0;
  assign m_axi_arlen   = '0;
  assign m_axi_awsize  = 3'($clog2(AXI_STRB_WIDTH));
  assign m_axi_arsize  = 3'($clog2(AXI_STRB_WIDTH));
  assign m_axi_awburst = 2'b01;
  assign m_axi_arburst = 2'b01;
  assign m_axi_awlock  = 1'b0;
  assign m_axi_arlock  = 1'b0;
  assign m_axi_awcache = 4'b0011;
  assign m_axi_arcache = 4'b0011;
  assign m_axi_awprot  = 3'b000;
  assign m_axi_arprot  = owner ? 3'b000 : 3'b100;
  assign m_axi_wdata   = wdata;
  assign m_axi_wstrb   = be;
  assign m_axi_wlast   = 1'b1;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= IDLE;
      owner         <= 1'b0;
      ptr           <= 1'b0;
      addr          <= '0;
      wdata         <= '0;
      be            <= '0;
      m_axi_arvalid <= 1'b0;
      m_axi_awvalid <= 1'b0;
      m_axi_wvalid  <= 1'b0;
      m_axi_rready  <= 1'b0;
      m_axi_bready  <= 1'b0;
      if_gnt        <= 1'b0;
      lsu_gnt       <= 1'b0;
      if_rvalid     <= 1'b0;
      lsu_rvalid    <= 1'b0;
      if_rdata      <= '0;
      lsu_rdata     <= '0;
`ifdef ADMO_MEM_ARB_RESP_ERR_EN
      if_err        <= 1'b0;
      lsu_err       <= 1'b0;
`endif
    end else begin
      if_gnt     <= 1'b0;
      lsu_gnt    <= 1'b0;
      if_rvalid  <= 1'b0;
      lsu_rvalid <= 1'b0;
      case (state)
        IDLE: if (if_req | lsu_req) begin
          owner   <= win;
          ptr     <= ~win;
          addr    <= (win ? lsu_addr : if_addr) & AMASK;
          wdata   <= lsu_wdata;
          be      <= lsu_be;
          if_gnt  <= ~win;
          lsu_gnt <= win;
          if (win & lsu_we) begin
            state         <= WR;
            m_axi_awvalid <= 1'b1;
            m_axi_wvalid  <= 1'b1;
          end else begin
            state         <= AR;
            m_axi_arvalid <= 1'b1;
          end
        end
        AR: if (m_axi_arready) begin
          m_axi_arvalid <= 1'b0;
          m_axi_rready  <= 1'b1;
          state         <= R;
        end
        R: if (m_axi_rvalid) begin
          m_axi_rready <= 1'b0;
          if_rvalid    <= ~owner;
          lsu_rvalid   <= owner;
          if (owner) lsu_rdata <= m_axi_rdata;
          else if_rdata <= m_axi_rdata;
`ifdef ADMO_MEM_ARB_RESP_ERR_EN
          if (owner) lsu_err <= m_axi_rresp[1];
          else if_err <= m_axi_rresp[1];
`endif
          state        <= IDLE;
        end
        WR: begin
          // address and data channels retire independently
          m_axi_awvalid <= aw_left;
          m_axi_wvalid  <= w_left;
          if (!aw_left && !w_left) begin
            m_axi_bready <= 1'b1;
            state        <= B;
          end
        end
        B: if (m_axi_bvalid) begin
          m_axi_bready <= 1'b0;
          lsu_rvalid   <= 1'b1;
          lsu_rdata    <= '0;
`ifdef ADMO_MEM_ARB_RESP_ERR_EN
          lsu_err      <= m_axi_bresp[1];
`endif
          state        <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_admo_mem_arb.sv
// tb_admo_mem_arb: randomized scoreboard bench for admo_mem_arb with an AXI slave and word-memory reference
`timescale 1ns/1ps
module tb_admo_mem_arb;
  logic clk = 1'b0, rst = 1'b0;
  always #5 clk = ~clk;
  logic if_req = 0, if_gnt, if_rvalid;
  logic [15:0] if_addr = 0;
  logic [31:0] if_rdata;
  logic lsu_req = 0, lsu_we = 0, lsu_gnt, lsu_rvalid;
  logic [15:0] lsu_addr = 0;
  logic [31:0] lsu_wdata = 0, lsu_rdata;
  logic [3:0] lsu_be = 0;
`ifdef ADMO_MEM_ARB_RESP_ERR_EN
  logic if_err, lsu_err;
`endif
  logic [7:0] m_axi_awid, m_axi_arid, m_axi_awlen, m_axi_arlen;
  logic [7:0] m_axi_bid = 8'd1, m_axi_rid = 0;
  logic [15:0] m_axi_awaddr, m_axi_araddr;
  logic [2:0] m_axi_awsize, m_axi_arsize, m_axi_awprot, m_axi_arprot;
  logic [1:0] m_axi_awburst, m_axi_arburst, m_axi_bresp = 0, m_axi_rresp = 0;
  logic m_axi_awlock, m_axi_arlock, m_axi_wlast, m_axi_rlast = 1'b1;
  logic [3:0] m_axi_awcache, m_axi_arcache, m_axi_wstrb;
  logic [31:0] m_axi_wdata, m_axi_rdata = 0;
  logic m_axi_awvalid, m_axi_wvalid, m_axi_arvalid, m_axi_bready, m_axi_rready;
  logic m_axi_awready = 0, m_axi_wready = 0, m_axi_arready = 0, m_axi_bvalid = 0, m_axi_rvalid = 0;

  admo_mem_arb dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .lsu_req(lsu_req), .lsu_we(lsu_we), .lsu_addr(lsu_addr), .lsu_wdata(lsu_wdata), .lsu_be(lsu_be),
    .lsu_gnt(lsu_gnt), .lsu_rvalid(lsu_rvalid), .lsu_rdata(lsu_rdata),
`ifdef ADMO_MEM_ARB_RESP_ERR_EN
    .if_err(if_err), .lsu_err(lsu_err),
`endif
    .m_axi_awid(m_axi_awid), .m_axi_awaddr(m_axi_awaddr), .m_axi_awlen(m_axi_awlen),
    .m_axi_awsize(m_axi_awsize), .m_axi_awburst(m_axi_awburst), .m_axi_awlock(m_axi_awlock),
    .m_axi_awcache(m_axi_awcache), .m_axi_awprot(m_axi_awprot), .m_axi_awvalid(m_axi_awvalid),
    .m_axi_awready(m_axi_awready), .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb),
    .m_axi_wlast(m_axi_wlast), .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
    .m_axi_bid(m_axi_bid), .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready),
    .m_axi_arid(m_axi_arid), .m_axi_araddr(m_axi_araddr), .m_axi_arlen(m_axi_arlen),
    .m_axi_arsize(m_axi_arsize), .m_axi_arburst(m_axi_arburst), .m_axi_arlock(m_axi_arlock),
    .m_axi_arcache(m_axi_arcache), .m_axi_arprot(m_axi_arprot), .m_axi_arvalid(m_axi_arvalid),
    .m_axi_arready(m_axi_arready), .m_axi_rid(m_axi_rid), .m_axi_rdata(m_axi_rdata),
    .m_axi_rresp(m_axi_rresp), .m_axi_rlast(m_axi_rlast), .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready)
  );

  int n_cmp = 0, n_bad = 0;
  logic [31:0] rmem [int];
  logic [31:0] smem [int];
  logic [31:0] if_q [$];
  logic [31:0] lsu_q [$];
  logic if_eq [$];
  logic lsu_eq [$];
  logic gord [$];
  int dly [5] = '{0, 0, 0, 0, 0};
  logic busy = 0, last = 1, pif = 0, plsu = 0, ew;
  logic [15:0] paif = 0, palsu = 0, gaddr = 0;

  task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h at %0t", n, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] init_w(input int k);
    return 32'hA5C3_0000 ^ (k * 32'h0001_9E37);
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] d, input logic [3:0] s);
    for (int i = 0; i < 4; i++) if (s[i]) o[8*i +: 8] = d[8*i +: 8];
    return o;
  endfunction

  function automatic logic [31:0] ref_rd(input logic [15:0] a);
    int k = int'(a >> 2);
    return rmem.exists(k) ? rmem[k] : init_w(k);
  endfunction

  function automatic logic [31:0] slv_rd(input logic [15:0] a);
    int k = int'(a >> 2);
    return smem.exists(k) ? smem[k] : init_w(k);
  endfunction

  function automatic int pick(input int i);
    return dly[i] < 0 ? int'($urandom_range(0, 3)) : dly[i];
  endfunction

  // Requesters: hold req until gnt, then register the expected completion
  task automatic if_txn(input logic [15:0] a);
    int t = 0;
    if_req = 1; if_addr = a;
    do begin @(negedge clk); t++; end while (!if_gnt && t < 400);
    chk("if_gnt_seen", if_gnt, 1);
    if_req = 0; if_addr = 16'($urandom);
    if (if_gnt) begin
      if_q.push_back(ref_rd(a));
      t = 0;
      do begin @(negedge clk); t++; end while (!if_rvalid && t < 400);
      chk("if_rvalid_seen", if_rvalid, 1);
    end
  endtask

  task automatic lsu_txn(input logic we, input logic [15:0] a, input logic [31:0] d, input logic [3:0] s);
    int t = 0;
    lsu_req = 1; lsu_we = we; lsu_addr = a; lsu_wdata = d; lsu_be = s;
    do begin @(negedge clk); t++; end while (!lsu_gnt && t < 400);
    chk("lsu_gnt_seen", lsu_gnt, 1);
    lsu_req = 0; lsu_we = 1'($urandom); lsu_addr = 16'($urandom); lsu_wdata = $urandom; lsu_be = 4'($urandom);
    if (lsu_gnt) begin
      if (we) begin
        rmem[int'(a >> 2)] = merge(ref_rd(a), d, s);
        lsu_q.push_back(32'h0);
      end else lsu_q.push_back(ref_rd(a));
      t = 0;
      do begin @(negedge clk); t++; end while (!lsu_rvalid && t < 400);
      chk("lsu_rvalid_seen", lsu_rvalid, 1);
    end
  endtask

  always @(posedge clk) begin
    pif = if_req; plsu = lsu_req; paif = if_addr; palsu = lsu_addr;
  end

  // AXI slave: handshakes sampled at posedge, responses driven at negedge
  logic ar_hs = 0, r_hs = 0, aw_hs = 0, w_hs = 0, b_hs = 0;
  logic ar_on = 0, r_on = 0, aw_on = 0, w_on = 0, b_on = 0, aw_done = 0, w_done = 0, ar_stall = 0;
  int ar_cnt = 0, r_cnt = 0, aw_cnt = 0, w_cnt = 0, b_cnt = 0;
  logic [15:0] r_a = 0, aw_a = 0, ar_hold = 0;
  logic [7:0] r_idv = 0;
  logic [31:0] w_d = 0;
  logic [3:0] w_s = 0;
  initial begin
    forever begin
      @(posedge clk);
      ar_hs = m_axi_arvalid & m_axi_arready;
      r_hs = m_axi_rvalid & m_axi_rready;
      aw_hs = m_axi_awvalid & m_axi_awready;
      w_hs = m_axi_wvalid & m_axi_wready;
      b_hs = m_axi_bvalid & m_axi_bready;
      if (rst) begin
        if (ar_stall) begin
          chk("ar_hold_valid", m_axi_arvalid, 1);
          chk("ar_hold_addr", m_axi_araddr, ar_hold);
        end
        ar_stall = m_axi_arvalid & ~m_axi_arready;
        ar_hold = m_axi_araddr;
        if (ar_hs) begin
          chk("ar_fields", {m_axi_arlen, m_axi_arsize, m_axi_arburst, m_axi_arlock, m_axi_arcache},
              {8'd0, 3'd2, 2'b01, 1'b0, 4'b0011});
          chk("ar_addr", m_axi_araddr, gaddr);
          chk("ar_id", m_axi_arid, {7'd0, last});
          chk("ar_prot", m_axi_arprot, last ? 3'b000 : 3'b100);
          r_a = m_axi_araddr; r_idv = m_axi_arid;
        end
        if (aw_hs) begin
          chk("aw_once", aw_done, 0);
          chk("aw_fields", {m_axi_awlen, m_axi_awsize, m_axi_awburst, m_axi_awlock, m_axi_awcache, m_axi_awprot, m_axi_awid},
              {8'd0, 3'd2, 2'b01, 1'b0, 4'b0011, 3'b000, 8'd1});
          chk("aw_addr", m_axi_awaddr, gaddr);
          aw_a = m_axi_awaddr; aw_done = 1;
        end
        if (w_hs) begin
          chk("w_once", w_done, 0);
          chk("wlast", m_axi_wlast, 1);
          w_d = m_axi_wdata; w_s = m_axi_wstrb; w_done = 1;
        end
      end
      @(negedge clk);
      if (!rst) begin
        m_axi_arready = 0; m_axi_awready = 0; m_axi_wready = 0; m_axi_rvalid = 0; m_axi_bvalid = 0;
        ar_on = 0; r_on = 0; aw_on = 0; w_on = 0; b_on = 0; aw_done = 0; w_done = 0; ar_stall = 0;
      end else begin
        if (ar_hs) begin m_axi_arready = 0; ar_on = 0; r_on = 1; r_cnt = pick(1); end
        else if (m_axi_arvalid && !m_axi_arready) begin
          if (!ar_on) begin ar_on = 1; ar_cnt = pick(0); end
          if (ar_cnt == 0) m_axi_arready = 1; else ar_cnt--;
        end
        if (r_hs) begin m_axi_rvalid = 0; r_on = 0; end
        else if (r_on && !m_axi_rvalid) begin
          if (r_cnt == 0) begin
            m_axi_rvalid = 1; m_axi_rdata = slv_rd(r_a); m_axi_rresp = 2'($urandom); m_axi_rid = r_idv;
            if (r_idv[0]) lsu_eq.push_back(m_axi_rresp[1]); else if_eq.push_back(m_axi_rresp[1]);
          end else r_cnt--;
        end
        if (aw_hs) begin m_axi_awready = 0; aw_on = 0; end
        else if (m_axi_awvalid && !m_axi_awready) begin
          if (!aw_on) begin aw_on = 1; aw_cnt = pick(2); end
          if (aw_cnt == 0) m_axi_awready = 1; else aw_cnt--;
        end
        if (w_hs) begin m_axi_wready = 0; w_on = 0; end
        else if (m_axi_wvalid && !m_axi_wready) begin
          if (!w_on) begin w_on = 1; w_cnt = pick(3); end
          if (w_cnt == 0) m_axi_wready = 1; else w_cnt--;
        end
        if (aw_done && w_done) begin
          smem[int'(aw_a >> 2)] = merge(slv_rd(aw_a), w_d, w_s);
          aw_done = 0; w_done = 0; b_on = 1; b_cnt = pick(4);
        end
        if (b_hs) begin m_axi_bvalid = 0; b_on = 0; end
        else if (b_on && !m_axi_bvalid) begin
          if (b_cnt == 0) begin
            m_axi_bvalid = 1; m_axi_bresp = 2'($urandom);
            lsu_eq.push_back(m_axi_bresp[1]);
          end else b_cnt--;
        end
      end
    end
  end

  // Monitor: arbitration order, one-outstanding rule, scoreboard pops on each rvalid
  always @(negedge clk) begin
    if (rst) begin
      if (if_gnt || lsu_gnt) begin
        chk("gnt_both", if_gnt & lsu_gnt, 0);
        chk("gnt_while_busy", busy, 0);
        chk("gnt_without_req", lsu_gnt ? plsu : pif, 1);
        ew = (pif && plsu) ? ~last : plsu;
        chk("arb_winner", lsu_gnt, ew);
        last = lsu_gnt; busy = 1; gord.push_back(lsu_gnt);
        gaddr = (lsu_gnt ? palsu : paif) & 16'hFFFC;
      end
      if (r_hs) chk("r_to_rvalid", last ? lsu_rvalid : if_rvalid, 1);
      if (b_hs) chk("b_to_lsu_rvalid", lsu_rvalid, 1);
      if (if_rvalid) begin
        chk("if_rvalid_owner", last, 0);
        if (if_q.size() == 0) chk("if_rvalid_unexpected", if_rvalid, 0);
        else chk("if_rdata", if_rdata, if_q.pop_front());
`ifdef ADMO_MEM_ARB_RESP_ERR_EN
        if (if_eq.size() != 0) chk("if_err", if_err, if_eq.pop_front());
`endif
        busy = 0;
      end
      if (lsu_rvalid) begin
        chk("lsu_rvalid_owner", last, 1);
        if (lsu_q.size() == 0) chk("lsu_rvalid_unexpected", lsu_rvalid, 0);
        else chk("lsu_rdata", lsu_rdata, lsu_q.pop_front());
`ifdef ADMO_MEM_ARB_RESP_ERR_EN
        if (lsu_eq.size() != 0) chk("lsu_err", lsu_err, lsu_eq.pop_front());
`endif
        busy = 0;
      end
    end
  end

  task automatic chk_quiet(input string n);
    chk({n, "_pulses"}, {if_gnt, lsu_gnt, if_rvalid, lsu_rvalid}, 0);
    chk({n, "_axi"}, {m_axi_arvalid, m_axi_awvalid, m_axi_wvalid, m_axi_rready, m_axi_bready}, 0);
    chk({n, "_rdata"}, {if_rdata, lsu_rdata}, 0);
  endtask

  initial begin
    logic [3:0] ord;
    repeat (2) @(negedge clk);
    #1 chk_quiet("reset");
    @(negedge clk); rst = 1;
    @(negedge clk);
    rmem[4] = 32'hDEADBEEF; smem[4] = 32'hDEADBEEF;
    if_req = 1; if_addr = 16'h0013;
    @(negedge clk);
    chk("lat_gnt", if_gnt, 1);
    chk("lat_arvalid", m_axi_arvalid, 1);
    chk("lat_araddr", m_axi_araddr, 16'h0010);
    chk("lat_arprot", m_axi_arprot, 3'b100);
    chk("lat_arid", m_axi_arid, 8'd0);
    if_req = 0; if_q.push_back(32'hDEADBEEF);
    @(negedge clk); chk("lat_rv_c2", if_rvalid, 0);
    @(negedge clk); chk("lat_rv_c3", if_rvalid, 1);
    @(negedge clk);
    dly = '{0, 0, 2, 0, 0};
    lsu_txn(1, 16'h0040, 32'h12345678, 4'b0011);
    lsu_txn(0, 16'h0042, 32'h0, 4'b0);
    dly = '{0, 0, 0, 0, 0};
    gord.delete();
    fork
      begin if_txn(16'h0200); if_txn(16'h0204); end
      begin lsu_txn(0, 16'h0208, 0, 0); lsu_txn(1, 16'h0200, 32'hCAFEF00D, 4'b1100); end
    join
    ord = 4'b1111;
    for (int i = 0; i < 4 && i < gord.size(); i++) ord[i] = gord[i];
    chk("rr_order", ord, 4'b1010);
    if_txn(16'h0200);
    dly = '{10, 0, 0, 0, 0};
    fork
      if_txn(16'h0300);
      begin @(negedge clk); lsu_txn(0, 16'h0304, 0, 0); end
    join
    dly = '{0, 6, 0, 0, 0};
    if_req = 1; if_addr = 16'h0100;
    @(negedge clk); chk("rst_gnt", if_gnt, 1); if_req = 0;
    @(negedge clk); chk("rst_in_r", m_axi_rready, 1);
    rst = 0;
    #1 chk_quiet("rst_mid");
    busy = 0; last = 1; if_q.delete(); lsu_q.delete(); if_eq.delete(); lsu_eq.delete();
    repeat (3) begin @(negedge clk); chk("rst_no_rvalid", {if_rvalid, lsu_rvalid}, 0); end
    rst = 1;
    dly = '{0, 0, 0, 0, 0};
    @(negedge clk);
    if_txn(16'h0100);
    dly = '{-1, -1, -1, -1, -1};
    fork
      for (int i = 0; i < 150; i++) begin
        repeat ($urandom_range(0, 3)) @(negedge clk);
        if_txn(16'($urandom_range(0, 255)));
      end
      for (int j = 0; j < 150; j++) begin
        repeat ($urandom_range(0, 3)) @(negedge clk);
        lsu_txn(1'($urandom), 16'($urandom_range(0, 255)), $urandom, 4'($urandom));
      end
    join
    repeat (4) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
    $fatal(1);
  end
endmodule
